// File: rtl/pipe_skid_buffer_pkg.sv
// Shared constants for the inter-stage pipeline buffers: buffer state encoding,
// occupancy width and the packed stage-field layout that sets the default DATA_W.
package pipe_buf_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    // Stage payload layout, MSB to LSB: {flags(ST,SST), operand, opcode, address}
    localparam int FLAG_W       = 2;
    localparam int OPND_W       = 16;
    localparam int OPCODE_W     = 6;
    localparam int ADDR_W       = 8;
    localparam int STAGE_DATA_W = FLAG_W + OPND_W + OPCODE_W + ADDR_W;

    function automatic logic [STAGE_DATA_W-1:0] pack_stage(
        input logic [FLAG_W-1:0]   flags,
        input logic [OPND_W-1:0]   opnd,
        input logic [OPCODE_W-1:0] opcode,
        input logic [ADDR_W-1:0]   addr
    );
        return {flags, opnd, opcode, addr};
    endfunction

endpackage

// File: rtl/pipe_skid_buffer_if.sv
// Upstream and downstream valid/ready links of one pipeline buffer.
interface pipe_skid_buffer_if #(
    parameter int DATA_W = 32
);
    // A beat moves on a clock edge where valid && ready are both high; the sender
    // holds data stable while valid is high and ready is low.
    logic [DATA_W-1:0] InData;
    logic              InValid;
    logic              InReady;
    logic [DATA_W-1:0] OutData;
    logic              OutValid;
    logic              OutReady;

    modport master (
        output InData, InValid, OutReady,
        input  InReady, OutData, OutValid
    );

    modport slave (
        input  InData, InValid, OutReady,
        output InReady, OutData, OutValid
    );
endinterface

// File: rtl/pipe_skid_buffer_sat_counter.sv
// Statistics counter with a variable increment; wraps or saturates depending on
// the mode input.
module sat_counter #(
    parameter int CNT_W = 16,
    parameter int INC_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sat_mode,
    input  logic [INC_W-1:0] i_inc,
    output logic [CNT_W-1:0] o_count
);
    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_next;

    always_comb begin
        w_sum  = {1'b0, r_count} + (CNT_W+1)'(i_inc);
        w_next = w_sum[CNT_W-1:0];
        if (i_sat_mode && w_sum[CNT_W]) begin
            w_next = '1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid pipeline register between datapath stages, with flush, freeze
// and transfer/drop statistics.
module pipe_skid_buffer
    import pipe_buf_pkg::*;
#(
    parameter int                 DATA_W    = STAGE_DATA_W,
    parameter int                 CNT_W     = 16,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    pipe_skid_buffer_if.slave bus,
    input  logic             Flush,
    input  logic             Freeze,
    output logic [OCC_W-1:0] Occupancy,
    output logic [CNT_W-1:0] XferCount,
    output logic [CNT_W-1:0] DropCount
);
    buf_state_t        r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [OCC_W-1:0]  w_xfer_inc;
    logic [OCC_W-1:0]  w_drop_inc;

    assign w_in_ready  = !Freeze && (r_state != ST_FULL);
    assign w_out_valid = !Freeze && (r_state != ST_EMPTY);
    assign w_in_fire   = bus.InValid && w_in_ready;
    assign w_out_fire  = w_out_valid && bus.OutReady;

    assign bus.InReady  = w_in_ready;
    assign bus.OutValid = w_out_valid;
    assign bus.OutData  = r_main;
    assign Occupancy    = r_state;

    // Flush wins over everything, including a transfer handshaking in the same cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_EMPTY;
            r_main  <= RESET_VAL;
            r_skid  <= RESET_VAL;
        end else if (Flush) begin
            r_state <= ST_EMPTY;
            r_main  <= RESET_VAL;
            r_skid  <= RESET_VAL;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= bus.InData;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= bus.InData;
                    end else if (w_in_fire) begin
                        r_skid  <= bus.InData;
                        r_state <= ST_FULL;
                    end else if (w_out_fire) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    assign w_xfer_inc = {1'b0, (w_out_fire && !Flush)};
    assign w_drop_inc = Flush ? r_state : '0;

    sat_counter #(.CNT_W(CNT_W), .INC_W(OCC_W)) u_xfer_cnt (
        .i_clk      (Clk),
        .i_rst      (Rst),
        .i_sat_mode (1'b0),
        .i_inc      (w_xfer_inc),
        .o_count    (XferCount)
    );

    sat_counter #(.CNT_W(CNT_W), .INC_W(OCC_W)) u_drop_cnt (
        .i_clk      (Clk),
        .i_rst      (Rst),
        .i_sat_mode (1'b1),
        .i_inc      (w_drop_inc),
        .o_count    (DropCount)
    );
endmodule
